// File: rtl/sd_pkg.sv
// Shared definitions for the SD command/data sequencer: command indices,
// error codes, the sequencer state encoding and the data-address helper.
// Optional feature macro: SD_SDHC_EN. When it is defined the card is treated
// as high capacity: HCS is set in the ACMD41 argument and the block number
// is used directly as the data address.
package sd_pkg;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD2   = 6'd2;
    localparam logic [5:0] CMD3   = 6'd3;
    localparam logic [5:0] CMD7   = 6'd7;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [5:0] ACMD6  = 6'd6;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD24  = 6'd24;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_CMD8    = 3'd2;
    localparam logic [2:0] ERR_ACMD41  = 3'd3;
    localparam logic [2:0] ERR_CRC     = 3'd4;

    localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;
    localparam logic [11:0] CMD8_ECHO  = 12'h1AA;
    localparam logic [31:0] ACMD6_ARG  = 32'h0000_0002;
`ifdef SD_SDHC_EN
    localparam logic [31:0] ACMD41_ARG = 32'h40FF_8000;
`else
    localparam logic [31:0] ACMD41_ARG = 32'h00FF_8000;
`endif

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CMD0      = 4'd1,
        ST_CMD8      = 4'd2,
        ST_CMD55_OP  = 4'd3,
        ST_ACMD41    = 4'd4,
        ST_CMD2      = 4'd5,
        ST_CMD3      = 4'd6,
        ST_CMD7      = 4'd7,
        ST_CMD55_BUS = 4'd8,
        ST_ACMD6     = 4'd9,
        ST_READY     = 4'd10,
        ST_CMD17     = 4'd11,
        ST_CMD24     = 4'd12,
        ST_DATA_RD   = 4'd13,
        ST_DATA_WR   = 4'd14,
        ST_ERROR     = 4'd15
    } sd_state_t;

    // Standard-capacity cards are byte addressed; high-capacity cards take
    // the block number directly.
    function automatic logic [31:0] data_addr(input logic [31:0] blk);
`ifdef SD_SDHC_EN
        return blk;
`else
        return {blk[22:0], 9'd0};
`endif
    endfunction

endpackage

// File: rtl/sd_cmd_step.sv
// One command (or data) step: issue pulse, done detection and a down-counting
// timeout. The data phase reuses the same counter with a 16x longer limit.
module sd_cmd_step
    import sd_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    input  logic scale16,
    input  logic done_evt,
    output logic start_pulse,
    output logic done,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT * 16);
    localparam logic [CW-1:0] LOAD_CMD  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] LOAD_DATA = CW'(TIMEOUT * 16 - 1);

    logic          active;
    logic [CW-1:0] cnt;

    // A done arriving on the terminal-count cycle still counts as done.
    assign done    = active & done_evt;
    assign timeout = active & ~done_evt & (cnt == '0);

    // Issue pulse follows go by one cycle; the counter is loaded alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_pulse <= 1'b0;
            active      <= 1'b0;
            cnt         <= '0;
        end else begin
            start_pulse <= go;
            if (go) begin
                active <= 1'b1;
                cnt    <= scale16 ? LOAD_DATA : LOAD_CMD;
            end else if (active) begin
                if (done_evt || cnt == '0)
                    active <= 1'b0;
                else
                    cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_sequencer.sv
// SD command/data sequencer: card identification at slow clock, switch to
// fast clock and 4-bit bus, then single-block read/write service.
// Optional feature macro: SD_SDHC_EN (high-capacity addressing, see sd_pkg).
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | after reset, waiting for istart_init
// ST_CMD0      | GO_IDLE; a timeout here is tolerated
// ST_CMD8      | interface condition, echo must be 0x1AA
// ST_CMD55_OP  | APP_CMD prefix ahead of ACMD41
// ST_ACMD41    | operating condition; loops via CMD55 while card busy
// ST_CMD2      | ALL_SEND_CID
// ST_CMD3      | SEND_RELATIVE_ADDR, captures RCA
// ST_CMD7      | select card, fast clock afterwards
// ST_CMD55_BUS | APP_CMD prefix ahead of ACMD6
// ST_ACMD6     | 4-bit bus width
// ST_READY     | idle, accepts read/write requests
// ST_CMD17     | READ_SINGLE_BLOCK command
// ST_CMD24     | WRITE_BLOCK command
// ST_DATA_RD   | data read transfer
// ST_DATA_WR   | data write transfer
// ST_ERROR     | sticky failure, left only on istart_init
//
// Each command/data state runs two phases tracked by 'issued': first cycle
// launches the step, then it waits for the step's done or timeout.
module sd_sequencer
    import sd_pkg::*;
#(
    parameter int ACMD41_TRIES = 1024,
    parameter int CMD_TIMEOUT  = 4096
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        istart_init,
    input  logic        iread_req,
    input  logic        iwrite_req,
    input  logic [31:0] iblock_addr,
    output logic        oready,
    output logic        obusy,
    output logic        oerror,
    output logic [2:0]  oerr_code,
    output logic        odone,
    output logic        osel_clk,
    output logic [5:0]  ocmd_index,
    output logic [31:0] ocmd_arg,
    output logic        ostart_cmd,
    input  logic        icmd_done,
    input  logic [31:0] iresp,
    output logic        ostart_d_read,
    output logic        ostart_d_write,
    input  logic        idata_done,
    input  logic        idata_crc_fail
);

    localparam int TW = $clog2(ACMD41_TRIES + 1);
    localparam logic [TW-1:0] TRY_LAST = TW'(ACMD41_TRIES - 1);

    sd_state_t     state, state_next;
    logic          issued, issued_next;
    logic [15:0]   rca, rca_next;
    logic [TW-1:0] try_cnt, try_next;
    logic [31:0]   blk_addr, blk_next;
    logic [5:0]    idx_next, cmd_index_sel;
    logic [31:0]   arg_next, cmd_arg_sel;
    logic          err_flag_next, sel_next, done_next;
    logic [2:0]    err_code_next;
    logic          fail;
    logic [2:0]    fail_code;
    logic          go, is_cmd_state, is_data_state;
    logic          step_pulse, step_done, step_timeout;
    logic          unused_resp;

    assign unused_resp = ^iresp[15:12];

    assign is_data_state = (state == ST_DATA_RD) || (state == ST_DATA_WR);
    assign is_cmd_state  = !is_data_state && (state != ST_IDLE) &&
                           (state != ST_READY) && (state != ST_ERROR);

    assign oready         = (state == ST_READY);
    assign obusy          = is_cmd_state || is_data_state;
    assign ostart_cmd     = step_pulse & is_cmd_state;
    assign ostart_d_read  = step_pulse & (state == ST_DATA_RD);
    assign ostart_d_write = step_pulse & (state == ST_DATA_WR);

    sd_cmd_step #(
        .TIMEOUT (CMD_TIMEOUT)
    ) u_step (
        .clk         (iclk),
        .rst_n       (irst),
        .go          (go),
        .scale16     (is_data_state),
        .done_evt    (is_data_state ? idata_done : icmd_done),
        .start_pulse (step_pulse),
        .done        (step_done),
        .timeout     (step_timeout)
    );

    // Command index and argument belonging to the current command state.
    always_comb begin
        cmd_index_sel = CMD0;
        cmd_arg_sel   = '0;
        case (state)
            ST_CMD8:      begin cmd_index_sel = CMD8;   cmd_arg_sel = CMD8_ARG;   end
            ST_CMD55_OP:  begin cmd_index_sel = CMD55;  end
            ST_ACMD41:    begin cmd_index_sel = ACMD41; cmd_arg_sel = ACMD41_ARG; end
            ST_CMD2:      begin cmd_index_sel = CMD2;   end
            ST_CMD3:      begin cmd_index_sel = CMD3;   end
            ST_CMD7:      begin cmd_index_sel = CMD7;   cmd_arg_sel = {rca, 16'h0}; end
            ST_CMD55_BUS: begin cmd_index_sel = CMD55;  cmd_arg_sel = {rca, 16'h0}; end
            ST_ACMD6:     begin cmd_index_sel = ACMD6;  cmd_arg_sel = ACMD6_ARG;  end
            ST_CMD17:     begin cmd_index_sel = CMD17;  cmd_arg_sel = data_addr(blk_addr); end
            ST_CMD24:     begin cmd_index_sel = CMD24;  cmd_arg_sel = data_addr(blk_addr); end
            default:      ;
        endcase
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_next    = state;
        issued_next   = issued;
        rca_next      = rca;
        try_next      = try_cnt;
        blk_next      = blk_addr;
        idx_next      = ocmd_index;
        arg_next      = ocmd_arg;
        err_flag_next = oerror;
        err_code_next = oerr_code;
        sel_next      = osel_clk;
        done_next     = 1'b0;
        go            = 1'b0;
        fail          = 1'b0;
        fail_code     = ERR_NONE;

        case (state)
            ST_IDLE, ST_ERROR: begin
                if (istart_init) begin
                    state_next    = ST_CMD0;
                    issued_next   = 1'b0;
                    err_flag_next = 1'b0;
                    err_code_next = ERR_NONE;
                    sel_next      = 1'b0;
                    try_next      = '0;
                    rca_next      = '0;
                end
            end
            ST_READY: begin
                if (iread_req) begin
                    blk_next   = iblock_addr;
                    state_next = ST_CMD17;
                end else if (iwrite_req) begin
                    blk_next   = iblock_addr;
                    state_next = ST_CMD24;
                end
            end
            default: begin
                if (!issued) begin
                    go          = 1'b1;
                    issued_next = 1'b1;
                    if (is_cmd_state) begin
                        idx_next = cmd_index_sel;
                        arg_next = cmd_arg_sel;
                    end
                end else if (step_done) begin
                    issued_next = 1'b0;
                    case (state)
                        ST_CMD0:     state_next = ST_CMD8;
                        ST_CMD8: begin
                            if (iresp[11:0] != CMD8_ECHO) begin
                                fail      = 1'b1;
                                fail_code = ERR_CMD8;
                            end else begin
                                state_next = ST_CMD55_OP;
                            end
                        end
                        ST_CMD55_OP: state_next = ST_ACMD41;
                        ST_ACMD41: begin
                            if (iresp[31]) begin
                                state_next = ST_CMD2;
                            end else if (try_cnt == TRY_LAST) begin
                                fail      = 1'b1;
                                fail_code = ERR_ACMD41;
                            end else begin
                                try_next   = try_cnt + 1'b1;
                                state_next = ST_CMD55_OP;
                            end
                        end
                        ST_CMD2:     state_next = ST_CMD3;
                        ST_CMD3: begin
                            rca_next   = iresp[31:16];
                            state_next = ST_CMD7;
                        end
                        ST_CMD7: begin
                            sel_next   = 1'b1;
                            state_next = ST_CMD55_BUS;
                        end
                        ST_CMD55_BUS: state_next = ST_ACMD6;
                        ST_ACMD6:     state_next = ST_READY;
                        ST_CMD17:     state_next = ST_DATA_RD;
                        ST_CMD24:     state_next = ST_DATA_WR;
                        ST_DATA_RD, ST_DATA_WR: begin
                            if (idata_crc_fail) begin
                                fail      = 1'b1;
                                fail_code = ERR_CRC;
                            end else begin
                                done_next  = 1'b1;
                                state_next = ST_READY;
                            end
                        end
                        default: ;
                    endcase
                end else if (step_timeout) begin
                    issued_next = 1'b0;
                    if (state == ST_CMD0) begin
                        state_next = ST_CMD8;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_TIMEOUT;
                    end
                end
            end
        endcase

        if (fail) begin
            state_next    = ST_ERROR;
            err_flag_next = 1'b1;
            err_code_next = fail_code;
            sel_next      = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state      <= ST_IDLE;
            issued     <= 1'b0;
            rca        <= '0;
            try_cnt    <= '0;
            blk_addr   <= '0;
            ocmd_index <= '0;
            ocmd_arg   <= '0;
            oerror     <= 1'b0;
            oerr_code  <= ERR_NONE;
            osel_clk   <= 1'b0;
            odone      <= 1'b0;
        end else begin
            state      <= state_next;
            issued     <= issued_next;
            rca        <= rca_next;
            try_cnt    <= try_next;
            blk_addr   <= blk_next;
            ocmd_index <= idx_next;
            ocmd_arg   <= arg_next;
            oerror     <= err_flag_next;
            oerr_code  <= err_code_next;
            osel_clk   <= sel_next;
            odone      <= done_next;
        end
    end

endmodule

// File: tb/tb_sd_sequencer.sv
// Directed bench for sd_sequencer with a small reactive card/transceiver model.
module tb_sd_sequencer;

    localparam int TRIES = 4;
    localparam int TMO   = 64;

`ifdef SD_SDHC_EN
    localparam logic [31:0] EXP_A41 = 32'h40FF8000;
    localparam logic [31:0] EXP_RD5 = 32'h00000005;
    localparam logic [31:0] EXP_RD7 = 32'h00000007;
    localparam logic [31:0] EXP_WR3 = 32'h00000003;
`else
    localparam logic [31:0] EXP_A41 = 32'h00FF8000;
    localparam logic [31:0] EXP_RD5 = 32'h00000A00;
    localparam logic [31:0] EXP_RD7 = 32'h00000E00;
    localparam logic [31:0] EXP_WR3 = 32'h00000600;
`endif

    logic        iclk = 1'b0, irst = 1'b0;
    logic        istart_init = 1'b0, iread_req = 1'b0, iwrite_req = 1'b0;
    logic [31:0] iblock_addr = '0;
    logic        oready, obusy, oerror, odone, osel_clk, ostart_cmd;
    logic        ostart_d_read, ostart_d_write;
    logic [2:0]  oerr_code;
    logic [5:0]  ocmd_index;
    logic [31:0] ocmd_arg;
    logic        icmd_done = 1'b0, idata_done = 1'b0, idata_crc_fail = 1'b0;
    logic [31:0] iresp = '0;

    // model configuration (written by the test sequence only)
    logic [31:0] cmd8_cfg = 32'h000001AA;
    int          busy_cfg = 0;
    logic        always_busy = 1'b0;
    logic        crc_cfg = 1'b0;
    int          hang_idx = -1;

    // model observations (written by the model only)
    int          n_cmd0 = 0, n_cmd8 = 0, n_cmd55 = 0, n_acmd41 = 0, n_cmd2 = 0;
    int          n_cmd17 = 0, n_cmd24 = 0, n_dread = 0, n_dwrite = 0, n_odone = 0;
    logic [31:0] cmd8_arg = '0, acmd41_arg = '0, cmd7_arg = '0, acmd6_arg = '0;
    logic [31:0] cmd17_arg = '0, cmd24_arg = '0;
    logic        sel_at_cmd7 = 1'b1;
    int          cmd2_cyc = 0, busy_left = 0, cmd_wait = 0, dat_wait = 0;
    logic [5:0]  cur_idx = '0;

    int          cyc = 0;
    int          checks = 0, errors = 0;

    sd_sequencer #(.ACMD41_TRIES(TRIES), .CMD_TIMEOUT(TMO)) dut (
        .iclk(iclk), .irst(irst), .istart_init(istart_init),
        .iread_req(iread_req), .iwrite_req(iwrite_req), .iblock_addr(iblock_addr),
        .oready(oready), .obusy(obusy), .oerror(oerror), .oerr_code(oerr_code),
        .odone(odone), .osel_clk(osel_clk), .ocmd_index(ocmd_index),
        .ocmd_arg(ocmd_arg), .ostart_cmd(ostart_cmd), .icmd_done(icmd_done),
        .iresp(iresp), .ostart_d_read(ostart_d_read), .ostart_d_write(ostart_d_write),
        .idata_done(idata_done), .idata_crc_fail(idata_crc_fail)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk) cyc <= cyc + 1;

    // Card/transceiver model: reacts on the falling edge, responses 3 cycles
    // after a command start, data completion 4 cycles after a data start.
    always @(negedge iclk) begin
        if (icmd_done) icmd_done = 1'b0;
        if (idata_done) begin
            idata_done     = 1'b0;
            idata_crc_fail = 1'b0;
        end
        if (odone) n_odone++;
        if (ostart_cmd) begin
            cur_idx = ocmd_index;
            case (ocmd_index)
                6'd0:  begin n_cmd0++; busy_left = busy_cfg; end
                6'd8:  begin n_cmd8++; cmd8_arg = ocmd_arg; end
                6'd55: n_cmd55++;
                6'd41: begin n_acmd41++; acmd41_arg = ocmd_arg; end
                6'd2:  begin n_cmd2++; cmd2_cyc = cyc; end
                6'd7:  begin cmd7_arg = ocmd_arg; sel_at_cmd7 = osel_clk; end
                6'd6:  acmd6_arg = ocmd_arg;
                6'd17: begin n_cmd17++; cmd17_arg = ocmd_arg; end
                6'd24: begin n_cmd24++; cmd24_arg = ocmd_arg; end
                default: ;
            endcase
            cmd_wait = (int'(ocmd_index) == hang_idx) ? 0 : 3;
        end else if (cmd_wait > 0) begin
            cmd_wait--;
            if (cmd_wait == 0) begin
                icmd_done = 1'b1;
                case (cur_idx)
                    6'd8:  iresp = cmd8_cfg;
                    6'd3:  iresp = 32'h12340000;
                    6'd41: begin
                        if (always_busy || busy_left > 0) begin
                            iresp = 32'h00FF8000;
                            if (busy_left > 0) busy_left--;
                        end else begin
                            iresp = 32'h80FF8000;
                        end
                    end
                    default: iresp = 32'h0;
                endcase
            end
        end
        if (ostart_d_read || ostart_d_write) begin
            if (ostart_d_read) n_dread++;
            if (ostart_d_write) n_dwrite++;
            dat_wait = 4;
        end else if (dat_wait > 0) begin
            dat_wait--;
            if (dat_wait == 0) begin
                idata_done     = 1'b1;
                idata_crc_fail = crc_cfg;
            end
        end
    end

    task automatic pulse_init();
        @(negedge iclk) istart_init = 1'b1;
        @(negedge iclk) istart_init = 1'b0;
    endtask

    task automatic wait_settle(input int max, input string name);
        int n = 0;
        while (!(oready || oerror) && n < max) begin
            @(negedge iclk);
            n++;
        end
        checks++;
        if (!(oready || oerror)) begin
            errors++;
            $display("FAIL %s: no ready/error within %0d cycles", name, max);
        end
    endtask

    task automatic do_reset();
        @(negedge iclk) irst = 1'b0;
        repeat (2) @(negedge iclk);
        irst = 1'b1;
        repeat (2) @(negedge iclk);
    endtask

    task automatic test_reset();
        irst = 1'b0;
        repeat (2) @(negedge iclk);
        checks++;
        if ({oready, obusy, oerror, odone, osel_clk, ostart_cmd, ostart_d_read, ostart_d_write} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000000",
                     {oready, obusy, oerror, odone, osel_clk, ostart_cmd, ostart_d_read, ostart_d_write});
        end
        checks++;
        if ({oerr_code, ocmd_index, ocmd_arg} !== 41'h0) begin
            errors++;
            $display("FAIL reset_values: code=%0d idx=%0d arg=%h required all zero", oerr_code, ocmd_index, ocmd_arg);
        end
        irst = 1'b1;
        @(negedge iclk);
        checks++;
        if ({obusy, ostart_cmd, ostart_d_read, ostart_d_write, odone} !== 5'b0) begin
            errors++;
            $display("FAIL reset_release: got %b required 00000", {obusy, ostart_cmd, ostart_d_read, ostart_d_write, odone});
        end
    endtask

    task automatic test_init();
        int a41 = n_acmd41, c55 = n_cmd55;
        busy_cfg = 2;
        pulse_init();
        checks++;
        if ({obusy, oready} !== 2'b10) begin
            errors++;
            $display("FAIL init_busy: busy/ready=%b required 10", {obusy, oready});
        end
        wait_settle(2000, "init_settle");
        checks++;
        if ({oready, obusy, oerror, osel_clk} !== 4'b1001) begin
            errors++;
            $display("FAIL init_ready: ready/busy/err/sel=%b required 1001", {oready, obusy, oerror, osel_clk});
        end
        checks++;
        if (n_acmd41 - a41 !== 3) begin
            errors++;
            $display("FAIL init_acmd41_count: got %0d required 3", n_acmd41 - a41);
        end
        checks++;
        if (n_cmd55 - c55 !== 4) begin
            errors++;
            $display("FAIL init_cmd55_count: got %0d required 4", n_cmd55 - c55);
        end
        checks++;
        if (cmd7_arg !== 32'h12340000) begin
            errors++;
            $display("FAIL init_cmd7_arg: got %h required 12340000", cmd7_arg);
        end
        checks++;
        if (sel_at_cmd7 !== 1'b0) begin
            errors++;
            $display("FAIL init_sel_before_cmd7: got %b required 0", sel_at_cmd7);
        end
        checks++;
        if ({cmd8_arg, acmd41_arg, acmd6_arg} !== {32'h000001AA, EXP_A41, 32'h00000002}) begin
            errors++;
            $display("FAIL init_args: cmd8=%h acmd41=%h acmd6=%h required 000001aa %h 00000002",
                     cmd8_arg, acmd41_arg, acmd6_arg, EXP_A41);
        end
    endtask

    task automatic test_read();
        int r = n_cmd17, d = n_dread, o = n_odone;
        @(negedge iclk) begin iblock_addr = 32'd5; iread_req = 1'b1; end
        @(negedge iclk) iread_req = 1'b0;
        checks++;
        if ({oready, obusy} !== 2'b01) begin
            errors++;
            $display("FAIL read_busy: ready/busy=%b required 01", {oready, obusy});
        end
        wait_settle(500, "read_settle");
        repeat (2) @(negedge iclk);
        checks++;
        if (cmd17_arg !== EXP_RD5 || n_cmd17 - r !== 1) begin
            errors++;
            $display("FAIL read_cmd17: arg=%h count=%0d required %h 1", cmd17_arg, n_cmd17 - r, EXP_RD5);
        end
        checks++;
        if (n_dread - d !== 1 || n_odone - o !== 1) begin
            errors++;
            $display("FAIL read_pulses: d_read=%0d odone=%0d required 1 1", n_dread - d, n_odone - o);
        end
        checks++;
        if ({oready, oerror} !== 2'b10) begin
            errors++;
            $display("FAIL read_back_ready: ready/err=%b required 10", {oready, oerror});
        end
    endtask

    task automatic test_collision_crc();
        int r = n_cmd17, w = n_cmd24, dw = n_dwrite, o;
        @(negedge iclk) begin iblock_addr = 32'd7; iread_req = 1'b1; iwrite_req = 1'b1; end
        @(negedge iclk) begin iread_req = 1'b0; iwrite_req = 1'b0; end
        wait_settle(500, "collide_settle");
        repeat (2) @(negedge iclk);
        checks++;
        if (n_cmd17 - r !== 1 || n_cmd24 - w !== 0 || n_dwrite - dw !== 0 || cmd17_arg !== EXP_RD7) begin
            errors++;
            $display("FAIL collide_read_only: cmd17=%0d cmd24=%0d dwrite=%0d arg=%h required 1 0 0 %h",
                     n_cmd17 - r, n_cmd24 - w, n_dwrite - dw, cmd17_arg, EXP_RD7);
        end
        crc_cfg = 1'b1;
        o = n_odone;
        @(negedge iclk) begin iblock_addr = 32'd3; iwrite_req = 1'b1; end
        @(negedge iclk) iwrite_req = 1'b0;
        wait_settle(500, "crc_settle");
        repeat (2) @(negedge iclk);
        checks++;
        if ({oerror, oerr_code, oready, osel_clk} !== {1'b1, 3'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL crc_error: err=%b code=%0d ready=%b sel=%b required 1 4 0 0", oerror, oerr_code, oready, osel_clk);
        end
        checks++;
        if (n_cmd24 - w !== 1 || cmd24_arg !== EXP_WR3 || n_odone - o !== 0) begin
            errors++;
            $display("FAIL crc_write: cmd24=%0d arg=%h odone=%0d required 1 %h 0", n_cmd24 - w, cmd24_arg, n_odone - o, EXP_WR3);
        end
        crc_cfg = 1'b0;
    endtask

    task automatic test_cmd8_mismatch();
        int c0, r;
        cmd8_cfg = 32'h000001AB;
        busy_cfg = 0;
        pulse_init();
        wait_settle(1000, "cmd8_settle");
        checks++;
        if ({oerror, oerr_code, osel_clk, oready} !== {1'b1, 3'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL cmd8_error: err=%b code=%0d sel=%b ready=%b required 1 2 0 0", oerror, oerr_code, osel_clk, oready);
        end
        cmd8_cfg = 32'h000001AA;
        c0 = n_cmd0;
        r  = n_cmd17;
        pulse_init();
        checks++;
        if ({oerror, oerr_code} !== 4'b0000) begin
            errors++;
            $display("FAIL reinit_clear: err=%b code=%0d required 0 0", oerror, oerr_code);
        end
        repeat (5) @(negedge iclk);
        istart_init = 1'b1;
        iread_req   = 1'b1;
        @(negedge iclk) begin istart_init = 1'b0; iread_req = 1'b0; end
        wait_settle(2000, "recover_settle");
        checks++;
        if ({oready, oerror, osel_clk} !== 3'b101) begin
            errors++;
            $display("FAIL recover_ready: ready/err/sel=%b required 101", {oready, oerror, osel_clk});
        end
        checks++;
        if (n_cmd0 - c0 !== 1 || n_cmd17 - r !== 0) begin
            errors++;
            $display("FAIL busy_ignores: cmd0=%0d cmd17=%0d required 1 0", n_cmd0 - c0, n_cmd17 - r);
        end
    endtask

    task automatic test_cmd_timeout();
        int c8, n, err_cyc;
        // asynchronous abort in the middle of initialisation
        do_reset();
        pulse_init();
        repeat (6) @(negedge iclk);
        @(posedge iclk);
        #2 irst = 1'b0;
        #1;
        checks++;
        if ({obusy, osel_clk, ostart_cmd, ocmd_index} !== 9'b0) begin
            errors++;
            $display("FAIL async_abort: busy=%b sel=%b start=%b idx=%0d required all zero", obusy, osel_clk, ostart_cmd, ocmd_index);
        end
        @(negedge iclk) irst = 1'b1;
        repeat (6) @(negedge iclk);
        // CMD0 never answered: tolerated
        hang_idx = 0;
        c8 = n_cmd8;
        pulse_init();
        wait_settle(2000, "cmd0_hang_settle");
        checks++;
        if ({oready, oerror} !== 2'b10 || n_cmd8 - c8 !== 1) begin
            errors++;
            $display("FAIL cmd0_timeout_ignored: ready/err=%b cmd8=%0d required 10 1", {oready, oerror}, n_cmd8 - c8);
        end
        // CMD2 never answered: timeout error after exactly TMO cycles
        do_reset();
        hang_idx = 2;
        pulse_init();
        n = 0;
        while (!oerror && n < 3000) begin
            @(negedge iclk);
            n++;
        end
        err_cyc = cyc;
        checks++;
        if (oerror !== 1'b1 || oerr_code !== 3'd1) begin
            errors++;
            $display("FAIL cmd2_timeout_code: err=%b code=%0d required 1 1", oerror, oerr_code);
        end
        checks++;
        if (err_cyc - cmd2_cyc !== TMO) begin
            errors++;
            $display("FAIL cmd2_timeout_len: got %0d cycles required %0d", err_cyc - cmd2_cyc, TMO);
        end
        hang_idx = -1;
    endtask

    task automatic test_acmd41_exhaust();
        int a41 = n_acmd41, c2 = n_cmd2;
        always_busy = 1'b1;
        pulse_init();
        wait_settle(2000, "acmd41_settle");
        checks++;
        if ({oerror, oerr_code, oready} !== {1'b1, 3'd3, 1'b0}) begin
            errors++;
            $display("FAIL acmd41_error: err=%b code=%0d ready=%b required 1 3 0", oerror, oerr_code, oready);
        end
        checks++;
        if (n_acmd41 - a41 !== TRIES || n_cmd2 - c2 !== 0) begin
            errors++;
            $display("FAIL acmd41_count: acmd41=%0d cmd2=%0d required %0d 0", n_acmd41 - a41, n_cmd2 - c2, TRIES);
        end
        always_busy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_read();
        test_collision_crc();
        test_cmd8_mismatch();
        test_cmd_timeout();
        test_acmd41_exhaust();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_sequencer.md
Name: sd_sequencer

Overview:
- Command/data sequencer driving the SD transceiver's command and data handshakes.
- After reset it runs card identification at the 281.25 kHz clock, switches the transceiver to 18 MHz and 4-bit bus, then serves single-block read/write requests from the cipher core.
- Sits between the top-level control FSM and the transceiver; sole owner of the transceiver's command, argument, clock-select and start inputs.

Parameters:
- ACMD41_TRIES, 1024, maximum CMD55/ACMD41 pairs before declaring init failure.
- CMD_TIMEOUT, 4096, iclk cycles allowed between a start pulse and its done pulse.

Ports:
- iclk  in  1  system clock, 36 MHz
- irst  in  1  asynchronous active-low reset
- istart_init  in  1  pulse: begin card initialisation
- iread_req  in  1  pulse: read one 512-byte block (accepted only when oready=1)
- iwrite_req  in  1  pulse: write one block (accepted only when oready=1)
- iblock_addr  in  32  block number, sampled with the request
- oready  out  1  card initialised and idle
- obusy  out  1  init or transfer in progress
- oerror  out  1  sticky failure flag; cleared by istart_init
- oerr_code  out  3  1 = timeout, 2 = CMD8 echo mismatch, 3 = ACMD41 exhausted, 4 = data CRC fail
- odone  out  1  one-cycle pulse when a read/write completes without error
- osel_clk  out  1  to transceiver; 0 = slow clock, 1 = fast clock
- ocmd_index  out  6  to transceiver
- ocmd_arg  out  32  to transceiver
- ostart_cmd  out  1  one-cycle pulse to transceiver
- icmd_done  in  1  pulse from transceiver
- iresp  in  32  response from transceiver, valid at icmd_done
- ostart_d_read  out  1  one-cycle pulse
- ostart_d_write  out  1  one-cycle pulse
- idata_done  in  1  pulse from transceiver
- idata_crc_fail  in  1  valid with idata_done

Behaviour:
- Reset values:
  - Outputs: all 0, ocmd_arg = 0, ocmd_index = 0, osel_clk = 0.
  - Internal: state IDLE, RCA = 0.
- Every command step has two phases:
  - ISSUE: drive index and argument, pulse ostart_cmd for 1 cycle.
  - WAIT: count cycles until icmd_done. Reaching CMD_TIMEOUT goes to ERROR with code 1.
- ocmd_index and ocmd_arg stay stable from ISSUE until done.
- Init chain, entered from IDLE or ERROR on istart_init:
  - CMD0, arg 0. Its timeout is ignored; proceed on icmd_done or timeout.
  - CMD8, arg 0x000001AA. iresp[11:0] != 0x1AA -> ERROR, code 2.
  - CMD55, arg 0.
  - ACMD41 (index 41). Argument per the optional feature.
  - If iresp[31] = 0 (card busy): increment the try counter and go back to CMD55. When the count reaches ACMD41_TRIES -> ERROR, code 3.
  - CMD2, arg 0.
  - CMD3, arg 0. Capture RCA = iresp[31:16].
  - CMD7, arg {RCA, 16'h0}. After its done, osel_clk = 1 and stays 1 until reset or re-init.
  - CMD55, arg {RCA, 16'h0}.
  - ACMD6, arg 0x00000002 (4-bit bus).
  - READY.
- READY:
  - oready = 1.
  - iread_req has priority over a simultaneous iwrite_req; the ignored request is dropped.
  - Read: CMD17 with the data address, then pulse ostart_d_read and wait for idata_done.
  - Write: CMD24 with the data address, then pulse ostart_d_write and wait for idata_done.
  - At idata_done: if idata_crc_fail -> ERROR, code 4; otherwise pulse odone and return to READY.
  - The data wait uses the same timeout counter, scaled by 16.
- Requests outside READY are ignored. oready=0 whenever obusy=1.
- istart_init while busy is ignored.
- ERROR:
  - oerror = 1, osel_clk forced to 0.
  - Leaves ERROR only on istart_init.
- Reset asserted mid-operation aborts at once. No pulse is emitted in the cycle reset releases.

Optional Feature:
- Macro: SD_SDHC_EN.
- Defined:
  - ACMD41 arg = 0x40FF8000 (HCS set).
  - Data address = iblock_addr unchanged.
- Undefined:
  - ACMD41 arg = 0x00FF8000.
  - Data address = iblock_addr << 9 (byte address; upper bits truncated to 32).

Decomposition:
- Shared package sd_pkg holds:
  - command index constants: CMD0, CMD2, CMD3, CMD7, CMD8, CMD55, ACMD41, ACMD6, CMD17, CMD24
  - the error-code localparams
  - the state enum
- One sub-module, sd_cmd_step: issue pulse, done/timeout detection, timeout counter. It is reused for the data wait through a scale input.

Test Plan:
- Reset, istart_init; card model answers CMD8 with 0x1AA and ACMD41 busy twice, then 0x80FF8000; CMD3 resp 0x12340000 -> CMD55/41 pairs issued 3 times, CMD7 arg 0x12340000, osel_clk rises after CMD7, oready = 1.
- CMD8 resp 0x000001AB -> oerror = 1, oerr_code = 2, osel_clk = 0; then istart_init with a correct model -> recovers to oready.
- Model never asserts icmd_done on CMD2 -> after CMD_TIMEOUT cycles, oerr_code = 1.
- From READY, iblock_addr = 5 and iread_req -> CMD17 arg 0xA00 (0x5 with SD_SDHC_EN), one ostart_d_read, idata_done, one odone pulse.
- iread_req and iwrite_req in the same cycle -> CMD17 only; then write with idata_crc_fail = 1 -> oerr_code = 4.
- ACMD41 always busy with ACMD41_TRIES = 4 -> exactly 4 ACMD41 issued, then oerr_code = 3.
